// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - clocked two-master arbiter for the shared internal memory port
//
// Port 1 (instruction fetch) and port 2 (data access) share one slave port.
// Port 2 wins by default. Port 1 is forced after STARVE_LIMIT consecutive
// port-2 grants made while it waited.
//
// Ports:
//   CLK, RESET              clock (rising edge), asynchronous active-low reset
//   HTRANS_1/HADDR_1/HWRITE_1/HWDATA_1  fetch master request
//   HREADY_1                one-cycle completion pulse for port 1
//   HTRANS_2/HADDR_2/HWRITE_2/HWDATA_2  data master request
//   HREADY_2                one-cycle completion pulse for port 2
//   PSEL/PADDR/PWRITE/PDATA registered slave access, held for WAIT_CYCLES
//   grant                   current owner: 0 none, 1 port 1, 2 port 2
//   stall                   fetch stall, HTRANS_1 & ~HREADY_1
module bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HTRANS_1,
  input  logic [ADDR_W-1:0] HADDR_1,
  input  logic              HWRITE_1,
  input  logic [DATA_W-1:0] HWDATA_1,
  output logic              HREADY_1,
  input  logic              HTRANS_2,
  input  logic [ADDR_W-1:0] HADDR_2,
  input  logic              HWRITE_2,
  input  logic [DATA_W-1:0] HWDATA_2,
  output logic              HREADY_2,
  output logic              PSEL,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PDATA,
  output logic [1:0]        grant,
  output logic              stall
);

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(WAIT_CYCLES - 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [SCW-1:0] starve_cnt;

  logic done;
  logic slot_free;
  logic any_req;
  logic pick_1;

  // Last cycle of the current access; slave read data is valid here.
  assign done      = (state == ACCESS) && (wait_cnt == '0);
  // A new access may start from IDLE or back-to-back after the last cycle.
  assign slot_free = (state == IDLE) || done;
  assign any_req   = HTRANS_1 | HTRANS_2;
  assign pick_1    = HTRANS_1 & (~HTRANS_2 | (starve_cnt == STARVE_MAX));

  assign HREADY_1 = done && (grant == 2'd1);
  assign HREADY_2 = done && (grant == 2'd2);
  assign stall    = HTRANS_1 & ~HREADY_1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      PSEL       <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PDATA      <= '0;
      grant      <= 2'd0;
    end else if (slot_free) begin
      if (any_req) begin
        state    <= ACCESS;
        PSEL     <= 1'b1;
        wait_cnt <= WAIT_LOAD;
        if (pick_1) begin
          grant      <= 2'd1;
          PADDR      <= HADDR_1;
          PWRITE     <= HWRITE_1;
          PDATA      <= HWDATA_1;
          starve_cnt <= '0;
        end else begin
          grant  <= 2'd2;
          PADDR  <= HADDR_2;
          PWRITE <= HWRITE_2;
          PDATA  <= HWDATA_2;
          // Only grants that bypass a waiting fetch count towards starvation.
          if (!HTRANS_1) begin
            starve_cnt <= '0;
          end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
      end else begin
        state      <= IDLE;
        PSEL       <= 1'b0;
        PWRITE     <= 1'b0;
        grant      <= 2'd0;
        starve_cnt <= '0;
      end
    end else begin
      wait_cnt <= wait_cnt - 1'b1;
      if (!HTRANS_1) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (WAIT_CYCLES 1 and 3)
module tb_bus_arbiter;

  localparam int LIMIT = 4;

  logic        CLK;
  logic        RESET;
  logic        HTRANS_1, HWRITE_1, HTRANS_2, HWRITE_2;
  logic [63:0] HADDR_1, HWDATA_1, HADDR_2, HWDATA_2;

  logic        psel_o   [2];
  logic        pwrite_o [2];
  logic        hr1_o    [2];
  logic        hr2_o    [2];
  logic        stall_o  [2];
  logic [63:0] paddr_o  [2];
  logic [63:0] pdata_o  [2];
  logic [1:0]  grant_o  [2];

  // Reference model: remaining access cycles (0 = idle), owner, starvation count.
  int          wc     [2] = '{1, 3};
  int          rem    [2];
  int          own    [2];
  int          starve [2];
  logic [63:0] m_addr [2];
  logic [63:0] m_data [2];
  logic        m_wr   [2];

  int n_cmp = 0;
  int n_bad = 0;

  int exp_seq [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_CYCLES(1), .STARVE_LIMIT(LIMIT)) u_w1 (
    .CLK(CLK), .RESET(RESET),
    .HTRANS_1(HTRANS_1), .HADDR_1(HADDR_1), .HWRITE_1(HWRITE_1), .HWDATA_1(HWDATA_1),
    .HREADY_1(hr1_o[0]),
    .HTRANS_2(HTRANS_2), .HADDR_2(HADDR_2), .HWRITE_2(HWRITE_2), .HWDATA_2(HWDATA_2),
    .HREADY_2(hr2_o[0]),
    .PSEL(psel_o[0]), .PADDR(paddr_o[0]), .PWRITE(pwrite_o[0]), .PDATA(pdata_o[0]),
    .grant(grant_o[0]), .stall(stall_o[0])
  );

  bus_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_CYCLES(3), .STARVE_LIMIT(LIMIT)) u_w3 (
    .CLK(CLK), .RESET(RESET),
    .HTRANS_1(HTRANS_1), .HADDR_1(HADDR_1), .HWRITE_1(HWRITE_1), .HWDATA_1(HWDATA_1),
    .HREADY_1(hr1_o[1]),
    .HTRANS_2(HTRANS_2), .HADDR_2(HADDR_2), .HWRITE_2(HWRITE_2), .HWDATA_2(HWDATA_2),
    .HREADY_2(hr2_o[1]),
    .PSEL(psel_o[1]), .PADDR(paddr_o[1]), .PWRITE(pwrite_o[1]), .PDATA(pdata_o[1]),
    .grant(grant_o[1]), .stall(stall_o[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i]    = 0;
      own[i]    = 0;
      starve[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic t1, input logic t2,
                            input logic [63:0] a1, input logic [63:0] a2,
                            input logic [63:0] d1, input logic [63:0] d2,
                            input logic w1, input logic w2);
    if (rem[i] <= 1) begin
      if (t1 || t2) begin
        if (t1 && (!t2 || starve[i] == LIMIT)) begin
          own[i] = 1; m_addr[i] = a1; m_data[i] = d1; m_wr[i] = w1;
          starve[i] = 0;
        end else begin
          own[i] = 2; m_addr[i] = a2; m_data[i] = d2; m_wr[i] = w2;
          if (t1) starve[i] = (starve[i] + 1 > LIMIT) ? LIMIT : starve[i] + 1;
          else    starve[i] = 0;
        end
        rem[i] = wc[i];
      end else begin
        rem[i]    = 0;
        own[i]    = 0;
        starve[i] = 0;
      end
    end else begin
      rem[i] = rem[i] - 1;
      if (!t1) starve[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      automatic logic busy = (rem[i] > 0);
      automatic logic e_r1 = (rem[i] == 1) && (own[i] == 1);
      automatic logic e_r2 = (rem[i] == 1) && (own[i] == 2);
      check_eq($sformatf("w%0d psel", wc[i]), 64'(psel_o[i]), 64'(busy));
      check_eq($sformatf("w%0d grant", wc[i]), 64'(grant_o[i]), busy ? 64'(own[i]) : 64'd0);
      check_eq($sformatf("w%0d hready_1", wc[i]), 64'(hr1_o[i]), 64'(e_r1));
      check_eq($sformatf("w%0d hready_2", wc[i]), 64'(hr2_o[i]), 64'(e_r2));
      check_eq($sformatf("w%0d stall", wc[i]), 64'(stall_o[i]), 64'(HTRANS_1 && !e_r1));
      if (busy) begin
        check_eq($sformatf("w%0d paddr", wc[i]), paddr_o[i], m_addr[i]);
        check_eq($sformatf("w%0d pwrite", wc[i]), 64'(pwrite_o[i]), 64'(m_wr[i]));
        check_eq($sformatf("w%0d pdata", wc[i]), pdata_o[i], m_data[i]);
      end
    end
  endtask

  // Called at posedge+1 with this cycle's inputs driven; returns at the next posedge+1.
  task automatic cycle();
    logic        t1, t2, w1, w2;
    logic [63:0] a1, a2, d1, d2;
    #1;
    compare_all();
    t1 = HTRANS_1; t2 = HTRANS_2; w1 = HWRITE_1; w2 = HWRITE_2;
    a1 = HADDR_1;  a2 = HADDR_2;  d1 = HWDATA_1; d2 = HWDATA_2;
    @(posedge CLK);
    for (int i = 0; i < 2; i++) model_edge(i, t1, t2, a1, a2, d1, d2, w1, w2);
    #1;
  endtask

  task automatic apply_reset();
    HTRANS_1 = 1'b0;
    HTRANS_2 = 1'b0;
    RESET    = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("w%0d rst psel", wc[i]), 64'(psel_o[i]), 64'd0);
      check_eq($sformatf("w%0d rst grant", wc[i]), 64'(grant_o[i]), 64'd0);
      check_eq($sformatf("w%0d rst paddr", wc[i]), paddr_o[i], 64'd0);
      check_eq($sformatf("w%0d rst pdata", wc[i]), pdata_o[i], 64'd0);
      check_eq($sformatf("w%0d rst pwrite", wc[i]), 64'(pwrite_o[i]), 64'd0);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET    = 1'b0;
    HTRANS_1 = 1'b0; HWRITE_1 = 1'b0; HADDR_1 = '0; HWDATA_1 = '0;
    HTRANS_2 = 1'b0; HWRITE_2 = 1'b0; HADDR_2 = '0; HWDATA_2 = '0;
    model_reset();

    // Single fetch.
    apply_reset();
    HTRANS_1 = 1'b1; HADDR_1 = 64'h100; HWRITE_1 = 1'b0;
    #1;
    check_eq("fetch stall_req", 64'(stall_o[0]), 64'd1);
    cycle();
    check_eq("fetch psel", 64'(psel_o[0]), 64'd1);
    check_eq("fetch paddr", paddr_o[0], 64'h100);
    check_eq("fetch grant", 64'(grant_o[0]), 64'd1);
    check_eq("fetch hready_1", 64'(hr1_o[0]), 64'd1);
    check_eq("fetch stall_rdy", 64'(stall_o[0]), 64'd0);
    HTRANS_1 = 1'b0;
    repeat (4) cycle();

    // Simultaneous requests: store on port 2 first, fetch back-to-back.
    apply_reset();
    HTRANS_1 = 1'b1; HADDR_1 = 64'h200;
    HTRANS_2 = 1'b1; HADDR_2 = 64'h8000; HWRITE_2 = 1'b1; HWDATA_2 = 64'hDEADBEEF;
    cycle();
    check_eq("simul grant_a", 64'(grant_o[0]), 64'd2);
    check_eq("simul pwrite", 64'(pwrite_o[0]), 64'd1);
    check_eq("simul pdata", pdata_o[0], 64'hDEADBEEF);
    check_eq("simul hready_2", 64'(hr2_o[0]), 64'd1);
    check_eq("simul stall_a", 64'(stall_o[0]), 64'd1);
    HTRANS_2 = 1'b0; HWRITE_2 = 1'b0;
    cycle();
    check_eq("simul grant_b", 64'(grant_o[0]), 64'd1);
    check_eq("simul paddr_b", paddr_o[0], 64'h200);
    check_eq("simul hready_1", 64'(hr1_o[0]), 64'd1);
    HTRANS_1 = 1'b0;
    repeat (6) cycle();

    // Starvation bound with both masters requesting continuously.
    apply_reset();
    HTRANS_1 = 1'b1; HADDR_1 = 64'h300;
    HTRANS_2 = 1'b1; HADDR_2 = 64'h9000;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check_eq($sformatf("starve grant[%0d]", k), 64'(grant_o[0]), 64'(exp_seq[k]));
    end
    HTRANS_1 = 1'b0; HTRANS_2 = 1'b0;
    repeat (6) cycle();

    // Three-cycle load with an address change mid-access.
    apply_reset();
    HTRANS_2 = 1'b1; HADDR_2 = 64'h40; HWRITE_2 = 1'b0;
    cycle();
    check_eq("w3 load psel_1", 64'(psel_o[1]), 64'd1);
    check_eq("w3 load paddr_1", paddr_o[1], 64'h40);
    check_eq("w3 load hready_1st", 64'(hr2_o[1]), 64'd0);
    HADDR_2 = 64'h99;
    cycle();
    check_eq("w3 load paddr_2", paddr_o[1], 64'h40);
    check_eq("w3 load hready_2nd", 64'(hr2_o[1]), 64'd0);
    cycle();
    check_eq("w3 load paddr_3", paddr_o[1], 64'h40);
    check_eq("w3 load hready_3rd", 64'(hr2_o[1]), 64'd1);
    HTRANS_2 = 1'b0;
    cycle();
    check_eq("w3 load psel_end", 64'(psel_o[1]), 64'd0);
    repeat (3) cycle();

    // Reset in the second of three access cycles.
    apply_reset();
    HTRANS_2 = 1'b1; HADDR_2 = 64'h40;
    cycle();
    cycle();
    RESET = 1'b0;
    #1;
    model_reset();
    check_eq("midrst psel", 64'(psel_o[1]), 64'd0);
    check_eq("midrst grant", 64'(grant_o[1]), 64'd0);
    check_eq("midrst hready_2", 64'(hr2_o[1]), 64'd0);
    check_eq("midrst paddr", paddr_o[1], 64'd0);
    #1;
    RESET = 1'b1;
    cycle();
    check_eq("midrst restart grant", 64'(grant_o[1]), 64'd2);
    check_eq("midrst restart psel", 64'(psel_o[1]), 64'd1);
    HTRANS_2 = 1'b0;
    repeat (4) cycle();

    // Idle bus.
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      cycle();
      check_eq("idle psel", 64'(psel_o[0] | psel_o[1]), 64'd0);
      check_eq("idle stall", 64'(stall_o[0] | stall_o[1]), 64'd0);
    end

    // Randomized traffic: drops, address changes and writes at any time.
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) < 2) HTRANS_1 = ~HTRANS_1;
      if ($urandom_range(0, 9) < 2) HTRANS_2 = ~HTRANS_2;
      if ($urandom_range(0, 2) == 0) begin
        HADDR_1  = {$urandom, $urandom};
        HWDATA_1 = {$urandom, $urandom};
        HWRITE_1 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 2) == 0) begin
        HADDR_2  = {$urandom, $urandom};
        HWDATA_2 = {$urandom, $urandom};
        HWRITE_2 = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Clocked two-master arbiter that shares the single internal memory port (irom / data memory) between instruction fetch (port 1) and data access (port 2). It replaces the purely combinational address mux. It latches the winning request and drives the shared slave port for a fixed number of access cycles. It returns per-port ready pulses and a fetch stall, and bounds fetch starvation under continuous data traffic.

Parameters:
ADDR_W, 64, address width of both masters and the slave port
DATA_W, 64, write-data width
WAIT_CYCLES, 1, slave access length in cycles (>=1); read data valid in last cycle
STARVE_LIMIT, 4, max consecutive port-2 grants while port 1 waits before port 1 is forced

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous active-low reset
HTRANS_1  input  1  fetch request; held high until HREADY_1
HADDR_1  input  ADDR_W  fetch address
HWRITE_1  input  1  fetch write flag (tied 0 in CPU, still honoured)
HWDATA_1  input  DATA_W  fetch write data
HREADY_1  output  1  one-cycle completion pulse for port 1
HTRANS_2  input  1  data request; held high until HREADY_2
HADDR_2  input  ADDR_W  data address
HWRITE_2  input  1  1 = store, 0 = load
HWDATA_2  input  DATA_W  store data
HREADY_2  output  1  one-cycle completion pulse for port 2
PSEL  output  1  slave access active
PADDR  output  ADDR_W  slave address
PWRITE  output  1  slave write enable
PDATA  output  DATA_W  slave write data
grant  output  2  0 = none, 1 = port 1, 2 = port 2 (current owner)
stall  output  1  fetch stall: HTRANS_1 & ~HREADY_1 (combinational)

Behaviour:
- Clock CLK; reset RESET is asynchronous and active-low. On reset: state IDLE, PSEL/PWRITE/HREADY_1/HREADY_2 = 0, PADDR/PDATA = 0, grant = 0, wait and starve counters = 0.
- States: IDLE, ACCESS.
- IDLE: if any HTRANS_x high at a rising edge, arbitrate, latch the winner's HADDR/HWRITE/HWDATA into PADDR/PWRITE/PDATA, set PSEL = 1, set grant, load wait counter = WAIT_CYCLES-1, and go to ACCESS. Otherwise stay in IDLE with PSEL = 0.
- Arbitration: port 2 wins by default. Port 1 wins if only port 1 requests, or if both request and starve counter == STARVE_LIMIT.
- Starve counter: +1 on each port-2 grant made while HTRANS_1 high. Cleared on a port-1 grant or whenever HTRANS_1 is low. Saturates at STARVE_LIMIT.
- ACCESS: slave outputs are held stable. Wait counter decrements each cycle. In the cycle the counter is 0, HREADY_<grant> = 1 (combinational from state/counter; slave read data is valid this cycle).
- At the edge ending that cycle: if any request is pending (excluding the just-served port's same request, whose HTRANS is sampled low or treated as a new request only if still high after HREADY), re-arbitrate and start the next access back-to-back with no idle cycle. Otherwise go to IDLE, PSEL = 0, grant = 0.
- Latency: request seen at edge N gives HREADY in cycle N+WAIT_CYCLES-1 after the grant edge. With WAIT_CYCLES = 1, HREADY asserts in the first ACCESS cycle.
- HTRANS dropped mid-access: the access still completes and HREADY still pulses. The master ignores it.
- Address/data change mid-access: ignored; latched values are used.
- Reset asserted mid-access: the access aborts immediately, with no HREADY and all outputs at reset values.
- Never more than one HREADY high in a cycle. PSEL = 0 implies both HREADY = 0.

Test Plan:
- Single fetch, WAIT_CYCLES=1: HTRANS_1=1, HADDR_1=0x100 -> next cycle PSEL=1, PADDR=0x100, grant=1, HREADY_1=1. stall=1 during the request cycle, 0 in the HREADY cycle.
- Simultaneous requests: HADDR_1=0x200, HADDR_2=0x8000 store HWDATA_2=0xDEADBEEF -> port 2 served first (PWRITE=1, PDATA=0xDEADBEEF), then port 1 back-to-back in the next cycle. stall high for 2 cycles.
- Starvation, STARVE_LIMIT=4: both held high continuously -> grant sequence 2,2,2,2,1,2,2,2,2,1.
- WAIT_CYCLES=3 load at 0x40 -> PSEL high for 3 cycles with PADDR stable. HREADY_2 only in the third cycle. Changing HADDR_2 mid-access has no effect.
- Reset mid-access: RESET low in the second of 3 wait cycles -> PSEL, grant and HREADY immediately 0. After release, the held request restarts from IDLE.
- Idle bus: no requests for 10 cycles -> PSEL=0, grant=0, stall=0 throughout.
